// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, control levels and fetch FSM encodings for the IF stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package if_fetch_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic RST_ENABLE   = 1'b1;

    localparam logic [INST_ADDR_W-1:0] BOOT_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        WAIT_RD = 2'd2,
        PAUSE   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding slot for a fetched instruction and its address.
// Latency: push visible the cycle after; clear beats push, push beats pop.
// Backpressure: none internally; the owner must not push while vld is set.
module if_skid_buf
    import if_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_dat,
    output logic              vld,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] dat
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] dat;
    } entry_t;

    entry_t entry_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            vld     <= 1'b0;
            entry_q <= '0;
        end else begin
            if (clear)     vld <= 1'b0;
            else if (push) vld <= 1'b1;
            else if (pop)  vld <= 1'b0;
            if (push && !clear) entry_q <= '{pc: push_pc, dat: push_dat};
        end
    end

    assign pc  = entry_q.pc;
    assign dat = entry_q.dat;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, the imem request handshake and the IF/ID output slot.
// Latency: first request two cycles after reset release; data reaches IF/ID the cycle after ack.
// Backpressure: a stalled ack lands in a one-entry skid and requests pause until it drains.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = BOOT_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_req,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic              ce,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [DATA_W-1:0] inst
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] redir_pc, redir_pc_n;
    logic              redir_flush, redir_flush_n;
    logic              inst_valid_n;
    logic [ADDR_W-1:0] inst_pc_n;
    logic [DATA_W-1:0] inst_n;
    logic              skid_push, skid_pop, skid_clr, skid_vld;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_dat;
    logic              consume, kill;
    logic [ADDR_W-1:0] redir_tgt;

    assign imem_req  = (state == FETCH) || (state == WAIT_RD);
    assign imem_addr = imem_req ? pc : '0;
    assign consume   = inst_valid && !stall_req;
    // A branch arriving behind a parked flush belongs to the flushed path.
    assign kill      = flush || (branch_flag && !((state == WAIT_RD) && redir_flush));
    assign redir_tgt = flush ? new_pc : branch_target;

    if_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (skid_push),
        .pop      (skid_pop),
        .clear    (skid_clr),
        .push_pc  (pc),
        .push_dat (imem_rdata),
        .vld      (skid_vld),
        .pc       (skid_pc),
        .dat      (skid_dat)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state       <= BOOT;
            ce          <= CHIP_DISABLE;
            pc          <= RESET_PC;
            redir_pc    <= '0;
            redir_flush <= 1'b0;
            inst_valid  <= 1'b0;
            inst_pc     <= '0;
            inst        <= '0;
        end else begin
            state       <= state_n;
            ce          <= CHIP_ENABLE;
            pc          <= pc_n;
            redir_pc    <= redir_pc_n;
            redir_flush <= redir_flush_n;
            inst_valid  <= inst_valid_n;
            inst_pc     <= inst_pc_n;
            inst        <= inst_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        redir_pc_n    = redir_pc;
        redir_flush_n = redir_flush;
        inst_valid_n  = inst_valid;
        inst_pc_n     = inst_pc;
        inst_n        = inst;
        skid_push     = 1'b0;
        skid_pop      = consume && skid_vld;
        skid_clr      = 1'b0;

        if (consume) begin
            if (skid_vld && !kill) begin
                inst_pc_n = skid_pc;
                inst_n    = skid_dat;
            end else begin
                inst_valid_n = 1'b0;
            end
        end

        unique case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    pc_n = pc + ADDR_W'(4);
                    if (!kill) begin
                        if (!inst_valid || !stall_req) begin
                            inst_valid_n = 1'b1;
                            inst_pc_n    = pc;
                            inst_n       = imem_rdata;
                        end else begin
                            skid_push = 1'b1;
                            state_n   = PAUSE;
                        end
                    end
                end
            end
            WAIT_RD: begin
                // Data for the killed fetch is dropped; the parked target takes over.
                if (imem_ack) begin
                    pc_n    = redir_pc;
                    state_n = FETCH;
                end
            end
            PAUSE: if (consume) state_n = FETCH;
            default: state_n = BOOT;
        endcase

        if (kill) begin
            skid_clr = 1'b1;
            if (flush) inst_valid_n = 1'b0;
            if (imem_req && !imem_ack) begin
                redir_pc_n    = redir_tgt;
                redir_flush_n = flush;
                state_n       = WAIT_RD;
            end else begin
                pc_n    = redir_tgt;
                state_n = FETCH;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for the fetch controller: reset exit, wait states, stall/skid, redirects, wrap.
// Latency: n/a. Backpressure: driven directly by the stimulus.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        ce;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .ce            (ce),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .inst          (inst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge, then drive this cycle's inputs and let outputs settle.
    task automatic cyc(input logic ack, input logic stl, input logic fl, input logic [31:0] np,
                       input logic br, input logic [31:0] bt);
        @(posedge clk);
        #1;
        imem_ack      = ack;
        stall_req     = stl;
        flush         = fl;
        new_pc        = np;
        branch_flag   = br;
        branch_target = bt;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"},   32'(ce),         32'd0);
        check({tag, "_req"},  32'(imem_req),   32'd0);
        check({tag, "_addr"}, imem_addr,       32'h0);
        check({tag, "_vld"},  32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst,            32'h0);
        check({tag, "_ipc"},  inst_pc,         32'h0);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b1; stall_req = 1'b0; flush = 1'b0; new_pc = '0;
        branch_flag = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Reset exit with zero-wait memory
        cyc(1, 0, 0, 0, 0, 0);
        check("boot_ce", 32'(ce), 32'd1);
        check("boot_req", 32'(imem_req), 32'd1);
        check("boot_addr", imem_addr, 32'h0);
        check("boot_vld", 32'(inst_valid), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("first_vld", 32'(inst_valid), 32'd1);
        check("first_ipc", inst_pc, 32'h0);
        check("first_inst", inst, mem_word(32'h0));
        check("seq_addr4", imem_addr, 32'h4);

        // Three wait states on 0x8
        cyc(0, 0, 0, 0, 0, 0);
        check("seq_addr8", imem_addr, 32'h8);
        check("ipc4", inst_pc, 32'h4);
        cyc(0, 0, 0, 0, 0, 0);
        check("wait_req", 32'(imem_req), 32'd1);
        check("wait_addr_a", imem_addr, 32'h8);
        check("wait_drained", 32'(inst_valid), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check("wait_addr_b", imem_addr, 32'h8);
        cyc(1, 0, 0, 0, 0, 0);
        check("wait_addr_c", imem_addr, 32'h8);
        cyc(1, 0, 0, 0, 0, 0);
        check("post_wait_addr", imem_addr, 32'hC);
        check("post_wait_ipc", inst_pc, 32'h8);
        check("post_wait_vld", 32'(inst_valid), 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        check("ipcC", inst_pc, 32'hC);

        // Stall four cycles with 0x10 at the output; 0x14 lands in the skid
        cyc(1, 1, 0, 0, 0, 0);
        check("stall_ipc10", inst_pc, 32'h10);
        check("stall_addr14", imem_addr, 32'h14);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            check("pause_noreq", 32'(imem_req), 32'd0);
            check("pause_hold", inst_pc, 32'h10);
        end
        cyc(1, 0, 0, 0, 0, 0);
        check("release_hold", inst_pc, 32'h10);
        cyc(1, 0, 0, 0, 0, 0);
        check("skid_out_ipc", inst_pc, 32'h14);
        check("skid_out_inst", inst, mem_word(32'h14));
        check("resume_addr", imem_addr, 32'h18);
        cyc(1, 0, 0, 0, 0, 0);
        check("resume_ipc18", inst_pc, 32'h18);
        cyc(1, 0, 0, 0, 0, 0);
        check("resume_ipc1c", inst_pc, 32'h1C);

        // Branch to 0x100 while 0x20 held and 0x24 in flight, ack two cycles late
        cyc(0, 1, 0, 0, 1, 32'h100);
        check("br_ipc20", inst_pc, 32'h20);
        check("br_addr24", imem_addr, 32'h24);
        cyc(0, 1, 0, 0, 0, 0);
        check("br_wait_req", 32'(imem_req), 32'd1);
        check("br_wait_addr", imem_addr, 32'h24);
        check("br_slot_vld", 32'(inst_valid), 32'd1);
        check("br_slot_ipc", inst_pc, 32'h20);
        cyc(1, 1, 0, 0, 0, 0);
        check("br_wait_addr2", imem_addr, 32'h24);
        cyc(1, 0, 0, 0, 0, 0);
        check("br_target_addr", imem_addr, 32'h100);
        check("br_slot_kept", inst_pc, 32'h20);
        cyc(1, 1, 0, 0, 0, 0);
        check("br_target_ipc", inst_pc, 32'h100);
        check("br_target_inst", inst, mem_word(32'h100));
        check("br_next_addr", imem_addr, 32'h104);

        // Flush with skid full
        cyc(1, 1, 1, 32'h180, 0, 0);
        check("fl_pause_req", 32'(imem_req), 32'd0);
        check("fl_pause_ipc", inst_pc, 32'h100);
        cyc(1, 0, 0, 0, 0, 0);
        check("fl_killed_vld", 32'(inst_valid), 32'd0);
        check("fl_addr", imem_addr, 32'h180);

        // Simultaneous flush and branch: flush wins
        cyc(1, 0, 1, 32'h180, 1, 32'h200);
        check("fl_deliver_ipc", inst_pc, 32'h180);
        check("fl_deliver_vld", 32'(inst_valid), 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        check("flbr_vld", 32'(inst_valid), 32'd0);
        check("flbr_addr", imem_addr, 32'h180);

        // Flush parked in WAIT_RD, then a branch that must be ignored
        cyc(0, 0, 1, 32'h300, 0, 0);
        check("park_ipc", inst_pc, 32'h180);
        check("park_addr", imem_addr, 32'h184);
        cyc(0, 0, 0, 0, 1, 32'h400);
        check("park_vld", 32'(inst_valid), 32'd0);
        check("park_req", 32'(imem_req), 32'd1);
        check("park_hold_addr", imem_addr, 32'h184);
        cyc(1, 0, 0, 0, 0, 0);
        check("park_ack_addr", imem_addr, 32'h184);
        cyc(0, 0, 0, 0, 0, 0);
        check("park_target", imem_addr, 32'h300);

        // Reset during a wait state; the late ack must be ignored
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ack = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cyc(1, 0, 0, 0, 0, 0);
        check("rerst_ce", 32'(ce), 32'd1);
        check("rerst_addr", imem_addr, 32'h0);
        check("rerst_vld", 32'(inst_valid), 32'd0);

        // Address wrap at the top of the space
        cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        check("rerst_ipc", inst_pc, 32'h0);
        cyc(1, 0, 0, 0, 0, 0);
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_top_vld", 32'(inst_valid), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("wrap_addr0", imem_addr, 32'h0);
        check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst", inst, mem_word(32'hFFFF_FFFC));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller that sequences the program counter and owns the instruction-memory request handshake. It sits between the PC datapath, the instruction ROM/bus and the IF/ID pipeline register. It absorbs memory wait states, downstream stalls, branch redirects and exception flushes. It presents at most one valid instruction per cycle to IF/ID.

Parameters:
ADDR_W, 32, width of PC and instruction address
DATA_W, 32, instruction width
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
stall_req  in  1  downstream (ID/EX) stall; IF/ID must not consume this cycle
branch_flag  in  1  branch/jump resolved in ID this cycle
branch_target  in  ADDR_W  branch destination
flush  in  1  exception/eret redirect; overrides branch
new_pc  in  ADDR_W  flush destination
ce  out  1  instruction memory chip enable
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address
imem_ack  in  1  request accepted, imem_rdata valid this cycle
imem_rdata  in  DATA_W  fetched instruction
inst_valid  out  1  inst/inst_pc valid toward IF/ID
inst_pc  out  ADDR_W  address of inst
inst  out  DATA_W  instruction to IF/ID

Behaviour:
- Reset (rst=1 at edge): state=BOOT, ce=0, pc=RESET_PC, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, skid empty, redir_pend=0. rst mid-transaction aborts it; a late ack is ignored.
- States: BOOT, FETCH, WAIT_RD (redirect pending), PAUSE.
- BOOT: first edge with rst=0 sets ce=1 and moves to FETCH. The first imem_req is seen the following cycle with imem_addr=RESET_PC (two-cycle reset-exit latency).
- FETCH: imem_req=1, imem_addr=pc. Request stays asserted and address stays stable until imem_ack; zero-wait ack in the same cycle is legal.
  - On ack: pc<=pc+4 (mod 2^ADDR_W, wrap 0xFFFFFFFC->0).
  - If the output slot is free or being consumed (!inst_valid || !stall_req): the data goes to the output register with inst_valid<=1 and inst_pc<=issued addr.
  - Otherwise the data goes into the 1-entry skid buffer.
- Consumption: inst_valid && !stall_req pops the output register. The skid, if full, refills it in the same edge; otherwise inst_valid<=0.
- Back-pressure: go to PAUSE, with imem_req deasserted from the next cycle, whenever the skid is full, or the skid will become full on this ack. No request is ever issued that cannot be stored. Return to FETCH when the skid drains.
- flush=1: kills the output register, the skid and any in-flight fetch.
  - inst_valid<=0.
  - If no request is outstanding, or ack arrives this cycle: pc<=new_pc and next req addr=new_pc.
  - Otherwise latch new_pc into redir_pend and go to WAIT_RD. Keep req/addr stable; discard data on ack; then pc<=redir target and return to FETCH.
- branch_flag=1 (no flush): kills the skid and the in-flight fetch only. The output register holds the delay slot and is retained. Target handling is identical to flush.
- Priorities: rst > flush > branch > stall. A flush while in WAIT_RD overwrites redir_pend. A branch in WAIT_RD with a flush already pending is ignored.
- stall_req never deasserts imem_req while a handshake is open.

Decomposition:
- Shared package/define file: InstAddrBus/InstBus widths, ChipEnable/ChipDisable, RstEnable, RESET_PC, and the fetch state encodings (2-bit).
- Natural sub-module: if_skid_buf (1-entry data+pc buffer with valid, push/pop/clear).

Test Plan:
- Reset release, ack always 1, no stall -> ce=1 one cycle after rst drop; imem_addr 0x0,0x4,0x8 on consecutive cycles; inst_valid rises the cycle after the first ack with inst_pc=0x0.
- Memory wait: ack held low 3 cycles on addr 0x8 -> imem_req/imem_addr=0x8 stable all 3 cycles; pc only advances to 0xC after ack.
- stall_req high 4 cycles at inst_pc=0x10 -> inst/inst_pc held at 0x10; skid holds 0x14; no req while skid full; after release the sequence continues 0x14, 0x18 with no loss or duplication.
- branch_flag to 0x100 while inst_pc=0x20 valid and fetch 0x24 in flight with ack delayed 2 cycles -> 0x20 retained, 0x24 data discarded, next req addr=0x100.
- flush new_pc=0x180 with skid full -> inst_valid=0 next cycle; skid cleared; next delivered inst_pc=0x180.
- Simultaneous flush(0x180)+branch(0x200) -> 0x180 wins; rst asserted during a wait state -> all outputs return to reset values next edge and the late ack is ignored.
